// File: rtl/fifo_control.sv
// rtl/fifo_control.sv - pointer, occupancy and flag controller for a dual-port FIFO memory
module fifo_control #(
    parameter int address_width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [address_width:0]   thr_high,
    input  logic [address_width:0]   thr_low,
    output logic                     wr_enable,
    output logic                     rd_enable,
    output logic [address_width-1:0] wr_ptr,
    output logic [address_width-1:0] rd_ptr,
    output logic [address_width:0]   occupancy,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     fifo_error,
    output logic                     data_out_valid
);

    localparam logic [address_width:0]   DEPTH_O = {1'b1, {address_width{1'b0}}};
    localparam logic [address_width:0]   ONE_O   = {{address_width{1'b0}}, 1'b1};
    localparam logic [address_width-1:0] ONE_P   = {{(address_width-1){1'b0}}, 1'b1};

    // Flags decode straight from the occupancy register and the live thresholds.
    always_comb begin
        full         = (occupancy == DEPTH_O);
        empty        = (occupancy == '0);
        almost_full  = (occupancy >= thr_high);
        almost_empty = (occupancy <= thr_low);
        wr_enable    = push & ~full & ~reset;
        rd_enable    = pop & ~empty & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occupancy      <= '0;
            fifo_error     <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            if (wr_enable)
                wr_ptr <= wr_ptr + ONE_P;
            if (rd_enable)
                rd_ptr <= rd_ptr + ONE_P;
            case ({wr_enable, rd_enable})
                2'b10:   occupancy <= occupancy + ONE_O;
                2'b01:   occupancy <= occupancy - ONE_O;
                default: occupancy <= occupancy;
            endcase
            // Sticky: any rejected request marks the FIFO as misused until reset.
            if ((push & full) | (pop & empty))
                fifo_error <= 1'b1;
            data_out_valid <= rd_enable;
        end
    end

endmodule

// File: tb/tb_fifo_control.sv
// tb/tb_fifo_control.sv - scoreboard bench for fifo_control against a queue-based reference model
module tb_fifo_control;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW:0]   thr_high = 9'd200;
    logic [AW:0]   thr_low = 9'd2;
    logic          wr_enable, rd_enable;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occupancy;
    logic          full, empty, almost_full, almost_empty, fifo_error, data_out_valid;

    fifo_control #(.address_width(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .thr_high(thr_high), .thr_low(thr_low),
        .wr_enable(wr_enable), .rd_enable(rd_enable),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .occupancy(occupancy),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_error(fifo_error), .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit we, re;
        int wp, rp, occ;
        bit full, empty, af, ae, err, dv;
    } exp_t;

    exp_t exp_q[$];
    int   stored[$];      // addresses written and not yet read, oldest first
    int   m_wp = 0;
    bit   m_err = 0;
    bit   m_dv = 0;
    bit   model_valid = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: every mid-cycle sample is matched against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_enable", 32'(wr_enable), 32'(e.we));
            chk("rd_enable", 32'(rd_enable), 32'(e.re));
            chk("wr_ptr", 32'(wr_ptr), e.wp);
            chk("rd_ptr", 32'(rd_ptr), e.rp);
            chk("occupancy", 32'(occupancy), e.occ);
            chk("full", 32'(full), 32'(e.full));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("almost_full", 32'(almost_full), 32'(e.af));
            chk("almost_empty", 32'(almost_empty), 32'(e.ae));
            chk("fifo_error", 32'(fifo_error), 32'(e.err));
            chk("data_out_valid", 32'(data_out_valid), 32'(e.dv));
        end
    end

    // One clock cycle: apply inputs, predict this cycle's outputs, advance the model.
    task automatic cyc(input bit r, input bit p, input bit q);
        exp_t e;
        int   occ;
        bit   wa, ra;
        reset = r;
        push  = p;
        pop   = q;
        occ = stored.size();
        wa = p && (occ < DEPTH) && !r;
        ra = q && (occ > 0) && !r;
        if (model_valid) begin
            e.we    = wa;
            e.re    = ra;
            e.wp    = m_wp;
            e.rp    = (occ == 0) ? m_wp : stored[0];
            e.occ   = occ;
            e.full  = (occ == DEPTH);
            e.empty = (occ == 0);
            e.af    = (occ >= int'(thr_high));
            e.ae    = (occ <= int'(thr_low));
            e.err   = m_err;
            e.dv    = m_dv;
            exp_q.push_back(e);
        end
        if (r) begin
            stored.delete();
            m_wp  = 0;
            m_err = 0;
            m_dv  = 0;
            model_valid = 1;
        end else begin
            if ((p && occ == DEPTH) || (q && occ == 0))
                m_err = 1;
            if (ra)
                void'(stored.pop_front());
            if (wa) begin
                stored.push_back(m_wp);
                m_wp = (m_wp + 1) % DEPTH;
            end
            m_dv = ra;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);

        thr_high = 9'd200;
        thr_low  = 9'd2;
        repeat (DEPTH) cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        repeat (DEPTH) cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        cyc(1, 0, 0);
        repeat (10) cyc(0, 1, 0);
        repeat (300) cyc(0, 1, 1);
        cyc(0, 0, 0);

        repeat (DEPTH - 10) cyc(0, 1, 0);
        cyc(0, 1, 1);
        repeat (DEPTH - 1) cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (36) cyc(0, 1, 0);
        cyc(1, 1, 0);
        repeat (2) cyc(0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, p, q;
            if ($urandom_range(0, 49) == 0) begin
                thr_high = 9'($urandom_range(0, 300));
                thr_low  = 9'($urandom_range(0, 300));
            end
            r = ($urandom_range(0, 299) == 0);
            p = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 30));
            q = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70));
            cyc(r, p, q);
        end
        cyc(0, 0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
